// File: rtl/hc_sr04_defs.sv
`default_nettype none
// ============================================================================
// Module      : hc_sr04_defs (package)
// Description : Shared state encoding, the microseconds-per-centimetre
//               constant and helpers deriving cycle counts from clock rate.
// Revision    : 1.0 - initial release
// ============================================================================
package hc_sr04_defs;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_ECHO = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_t;

  // Round-trip echo time per centimetre of range.
  localparam int US_PER_CM = 58;

  function automatic int cycles_per_us(input int clk_hz);
    return clk_hz / 1000000;
  endfunction

  function automatic int trig_cycles(input int clk_hz, input int trig_us);
    return (trig_us * clk_hz) / 1000000;
  endfunction

  function automatic int period_cycles(input int clk_hz, input int period_ms);
    return (period_ms * clk_hz) / 1000;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hc_sr04_ranger_us_tick.sv
`default_nettype none
// ============================================================================
// Module      : us_tick
// Description : Free-running prescaler producing a one-cycle tick once per
//               microsecond.
// Revision    : 1.0 - initial release
// ============================================================================
module us_tick #(
  parameter int CYCLES_PER_US = 12
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CYCLES_PER_US - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Wrap the divider on the last cycle of each microsecond.
  always_comb begin
    tick  = (cnt_q == C_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Divider register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/hc_sr04_ranger.sv
`default_nettype none
// ============================================================================
// Module      : hc_sr04_ranger
// Description : HC-SR04 ultrasonic ranger controller. Issues periodic trigger
//               pulses, times the echo in microseconds and reports the range
//               in whole centimetres, with timeout and saturation handling.
// Revision    : 1.0 - initial release
// ============================================================================
module hc_sr04_ranger #(
  parameter int CLK_HZ       = 12000000,
  parameter int TRIG_US      = 10,
  parameter int PERIOD_MS    = 60,
  parameter int ECHO_WAIT_US = 30000,
  parameter int MAX_CM       = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        echo,
  output logic        trig,
  output logic [15:0] distance,
  output logic        valid,
  output logic        timeout,
  output logic        busy
);

  import hc_sr04_defs::*;

  localparam int C_CYC_PER_US = cycles_per_us(CLK_HZ);
  localparam int C_TRIG_CYC   = trig_cycles(CLK_HZ, TRIG_US);
  localparam int C_PERIOD_CYC = period_cycles(CLK_HZ, PERIOD_MS);
  localparam int PW           = $clog2(C_PERIOD_CYC + 1);
  localparam int WW           = $clog2(ECHO_WAIT_US + 1);
  localparam int SW           = $clog2(US_PER_CM);

  localparam logic [PW-1:0] C_TRIG_LAST   = PW'(C_TRIG_CYC - 1);
  localparam logic [PW-1:0] C_PERIOD_LAST = PW'(C_PERIOD_CYC - 1);
  localparam logic [PW-1:0] C_PERIOD_SAT  = PW'(C_PERIOD_CYC);
  localparam logic [WW-1:0] C_WAIT_LAST   = WW'(ECHO_WAIT_US - 1);
  localparam logic [SW-1:0] C_SUB_LAST    = SW'(US_PER_CM - 1);
  localparam logic [15:0]   C_MAX_CM      = 16'(MAX_CM);

  state_t        state_q, state_d;
  logic [PW-1:0] period_q, period_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [SW-1:0] sub_q, sub_d, sub_inc;
  logic [15:0]   cm_q, cm_d, cm_inc;
  logic [15:0]   distance_q, distance_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
  logic          echo_s1_q, echo_s2_q, echo_prev_q;
  logic          echo_rise, echo_fall;
  logic          tick;

  us_tick #(.CYCLES_PER_US(C_CYC_PER_US)) u_us_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchronizer for the asynchronous echo plus a delayed copy for edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_s1_q   <= 1'b0;
      echo_s2_q   <= 1'b0;
      echo_prev_q <= 1'b0;
    end else begin
      echo_s1_q   <= echo;
      echo_s2_q   <= echo_s1_q;
      echo_prev_q <= echo_s2_q;
    end
  end

  assign echo_rise = echo_s2_q & ~echo_prev_q;
  assign echo_fall = ~echo_s2_q & echo_prev_q;

  // Centimetre accumulation: one cm per 58 microsecond ticks, truncating.
  always_comb begin
    sub_inc = sub_q;
    cm_inc  = cm_q;
    if (tick) begin
      if (sub_q == C_SUB_LAST) begin
        sub_inc = '0;
        cm_inc  = cm_q + 16'd1;
      end else begin
        sub_inc = sub_q + 1'b1;
      end
    end
  end

  // Next-state and datapath decisions for the ranging sequence.
  always_comb begin
    state_d    = state_q;
    period_d   = (period_q == C_PERIOD_SAT) ? period_q : period_q + 1'b1;
    wait_d     = wait_q;
    sub_d      = sub_q;
    cm_d       = cm_q;
    distance_d = distance_q;
    valid_d    = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        period_d = '0;
        if (en) state_d = ST_TRIG;
      end
      ST_TRIG: begin
        // The period counter starts at zero on the trigger rise, so it also
        // times the trigger width.
        if (period_q == C_TRIG_LAST) begin
          state_d = ST_WAIT_ECHO;
          wait_d  = '0;
        end
      end
      ST_WAIT_ECHO: begin
        if (echo_rise) begin
          state_d = ST_MEASURE;
          sub_d   = '0;
          cm_d    = '0;
        end else if (tick) begin
          if (wait_q == C_WAIT_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_HOLDOFF;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      ST_MEASURE: begin
        sub_d = sub_inc;
        cm_d  = cm_inc;
        // The tick landing in the fall cycle is counted so a window of N us
        // always sees exactly N ticks regardless of prescaler phase.
        if (cm_inc >= C_MAX_CM) begin
          distance_d = C_MAX_CM;
          valid_d    = 1'b1;
          state_d    = ST_HOLDOFF;
        end else if (echo_fall) begin
          distance_d = cm_inc;
          valid_d    = 1'b1;
          state_d    = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        // A stuck-high echo holds the block here until the line drops.
        if ((period_q >= C_PERIOD_LAST) && !echo_s2_q) begin
          if (en) begin
            state_d  = ST_TRIG;
            period_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      period_q   <= '0;
      wait_q     <= '0;
      sub_q      <= '0;
      cm_q       <= '0;
      distance_q <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      wait_q     <= wait_d;
      sub_q      <= sub_d;
      cm_q       <= cm_d;
      distance_q <= distance_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  // Pulse and status outputs are held low while reset is asserted.
  assign trig     = (state_q == ST_TRIG) && !rst;
  assign busy     = (state_q != ST_IDLE) && !rst;
  assign valid    = valid_q && !rst;
  assign timeout  = timeout_q && !rst;
  assign distance = distance_q;

endmodule
`default_nettype wire

// File: tb/tb_hc_sr04_ranger.sv
`default_nettype none
// ============================================================================
// Module      : tb_hc_sr04_ranger
// Description : Self-checking bench for hc_sr04_ranger using a scaled clock
//               (2 MHz, 1 ms period, 200 us echo wait, 12 cm ceiling).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hc_sr04_ranger;

  localparam int CLK_HZ       = 2000000;
  localparam int TRIG_US      = 10;
  localparam int PERIOD_MS    = 1;
  localparam int ECHO_WAIT_US = 200;
  localparam int MAX_CM       = 12;
  localparam int CPU          = CLK_HZ / 1000000;
  localparam int TRIG_CYC     = TRIG_US * CPU;
  localparam int PERIOD_CYC   = PERIOD_MS * CLK_HZ / 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        echo = 1'b0;
  logic        trig, valid, timeout, busy;
  logic [15:0] distance;

  hc_sr04_ranger #(
    .CLK_HZ(CLK_HZ), .TRIG_US(TRIG_US), .PERIOD_MS(PERIOD_MS),
    .ECHO_WAIT_US(ECHO_WAIT_US), .MAX_CM(MAX_CM)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .echo(echo), .trig(trig),
    .distance(distance), .valid(valid), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Monitor state, updated just after each rising edge.
  int          cyc = 0;
  int          valid_cnt = 0;
  int          to_cnt = 0;
  int          rise_cnt = 0;
  int          last_rise = 0;
  int          gap = 0;
  int          inv_fail = 0;
  int          last_dist = 0;
  logic        trig_prev = 1'b0;
  logic [15:0] dist_prev = 16'd0;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (valid) begin
      valid_cnt = valid_cnt + 1;
      last_dist = int'(distance);
    end
    if (timeout) to_cnt = to_cnt + 1;
    if (valid && timeout) inv_fail = inv_fail + 1;
    if (!rst && !valid && distance != dist_prev) inv_fail = inv_fail + 1;
    dist_prev = distance;
    if (trig && !trig_prev) begin
      rise_cnt  = rise_cnt + 1;
      gap       = cyc - last_rise;
      last_rise = cyc;
    end
    trig_prev = trig;
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: range is the echo width in whole 58 us steps, capped at MAX_CM.
  function automatic int ref_cm(input int len_us);
    int d;
    d = len_us / 58;
    return (d > MAX_CM) ? MAX_CM : d;
  endfunction

  // One measurement cycle. Entry: at a negedge in the first trig-high cycle.
  // Exit: at the negedge of the next trig-high cycle.
  task automatic meas(input string nm, input int delay_us, input int len_us,
                      input bit exp_to, input int exp_dist, input bit chk_gap,
                      output int relaunch);
    int n, v0, t0, r0;
    v0 = valid_cnt;
    t0 = to_cnt;
    n  = 0;
    while (trig && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk({nm, ".trig_width"}, n, TRIG_CYC);
    r0 = rise_cnt;
    if (len_us > 0) begin
      repeat (delay_us * CPU) @(negedge clk);
      echo = 1'b1;
      repeat (len_us * CPU) @(negedge clk);
      echo = 1'b0;
    end
    chk({nm, ".no_retrig_in_echo"}, rise_cnt - r0, 0);
    n = 0;
    while (valid_cnt == v0 && to_cnt == t0 && n < 3 * PERIOD_CYC) begin
      @(negedge clk);
      n++;
    end
    if (exp_to) begin
      chk({nm, ".timeout_pulses"}, to_cnt - t0, 1);
      chk({nm, ".timeout_late_ok"}, int'(n >= 395 && n <= 410), 1);
      chk({nm, ".valid_pulses"}, valid_cnt - v0, 0);
    end else begin
      chk({nm, ".valid_pulses"}, valid_cnt - v0, 1);
      chk({nm, ".timeout_pulses"}, to_cnt - t0, 0);
      chk({nm, ".valid_dist"}, last_dist, exp_dist);
    end
    chk({nm, ".distance"}, int'(distance), exp_dist);
    n = 0;
    while (!trig && n < 3 * PERIOD_CYC) begin
      @(negedge clk);
      n++;
    end
    relaunch = n;
    chk({nm, ".next_trig"}, int'(trig), 1);
    if (chk_gap) chk({nm, ".period"}, gap, PERIOD_CYC);
  endtask

  typedef struct {
    int delay_us;
    int len_us;
    bit exp_to;
    int exp_dist;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int relaunch, d, l, n, v0, r0;
    tbl[0] = '{30, 580, 1'b0, 10};
    tbl[1] = '{30,  57, 1'b0,  0};
    tbl[2] = '{30, 637, 1'b0, 10};
    tbl[3] = '{ 0,   0, 1'b1, 10};
    tbl[4] = '{20, 696, 1'b0, 12};
    tbl[5] = '{20, 695, 1'b0, 11};
    tbl[6] = '{100, 58, 1'b0,  1};
    tbl[7] = '{20, 800, 1'b0, 12};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst.trig", int'(trig), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.distance", int'(distance), 0);
    chk("rst.valid", int'(valid), 0);
    chk("rst.timeout", int'(timeout), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle.busy", int'(busy), 0);
    en = 1'b1;
    @(negedge clk);
    chk("first_trig_latency", int'(trig), 1);

    // Table-driven measurements.
    for (int i = 0; i < 8; i++)
      meas($sformatf("tbl%0d", i), tbl[i].delay_us, tbl[i].len_us,
           tbl[i].exp_to, tbl[i].exp_dist, 1'b1, relaunch);

    // Randomized echoes against the reference model.
    for (int i = 0; i < 8; i++) begin
      d = $urandom_range(150, 5);
      l = $urandom_range(760, 1);
      meas($sformatf("rnd%0d_d%0d_l%0d", i, d, l), d, l, 1'b0, ref_cm(l), 1'b1, relaunch);
    end

    // Echo stuck high past the period: saturate, then relaunch only once it drops.
    meas("stuck", 20, 1500, 1'b0, MAX_CM, 1'b0, relaunch);
    chk("stuck.relaunch_soon", int'(relaunch <= 6), 1);

    // Reset 100 us into an echo: discarded, cleared, then a fresh trigger.
    n = 0;
    while (trig && n < 1000) begin
      n++;
      @(negedge clk);
    end
    repeat (20 * CPU) @(negedge clk);
    echo = 1'b1;
    repeat (100 * CPU) @(negedge clk);
    v0  = valid_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.trig", int'(trig), 0);
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.distance", int'(distance), 0);
    echo = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.fresh_trig", int'(trig), 1);
    chk("midrst.no_valid", valid_cnt - v0, 0);

    // Dropping en mid-echo completes the measurement, then the block idles.
    n = 0;
    while (trig && n < 1000) begin
      n++;
      @(negedge clk);
    end
    repeat (20 * CPU) @(negedge clk);
    v0   = valid_cnt;
    echo = 1'b1;
    repeat (100 * CPU) @(negedge clk);
    en = 1'b0;
    repeat (300 * CPU) @(negedge clk);
    echo = 1'b0;
    r0 = rise_cnt;
    repeat (3 * PERIOD_CYC) @(negedge clk);
    chk("endrop.valid", valid_cnt - v0, 1);
    chk("endrop.distance", int'(distance), ref_cm(400));
    chk("endrop.no_retrig", rise_cnt - r0, 0);
    chk("endrop.idle", int'(busy), 0);

    chk("invariants", inv_fail, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hc_sr04_ranger.md
HC_SR04_RANGER -- requirements
Module: hc_sr04_ranger

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12000000, system clock frequency in Hz.
REQ-002 SHALL have parameter TRIG_US, default 10, trigger pulse width in microseconds.
REQ-003 SHALL have parameter PERIOD_MS, default 60, trigger-to-trigger measurement period in milliseconds.
REQ-004 SHALL have parameter ECHO_WAIT_US, default 30000, maximum wait from trigger end to echo rise.
REQ-005 SHALL have parameter MAX_CM, default 400, saturation distance in cm.
REQ-006 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port en, input, 1, continuous ranging enable.
REQ-009 SHALL have port echo, input, 1, asynchronous sensor echo pin.
REQ-010 SHALL have port trig, output, 1, sensor trigger pin.
REQ-011 SHALL have port distance, output, 16, last valid range in cm; the value the elevator motor controller consumes.
REQ-012 SHALL have port valid, output, 1, one-cycle pulse on each distance update.
REQ-013 SHALL have port timeout, output, 1, one-cycle pulse when no echo arrives.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL synchronize echo through two flops; all edge detection SHALL use the synchronized signal.
REQ-016 SHALL generate a 1 us tick every CLK_HZ/1000000 cycles, free-running from reset.
REQ-017 SHALL implement states IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF.
REQ-018 IDLE: when en=1, go to TRIG on the next clock and clear the period counter.
REQ-019 TRIG: hold trig=1 for exactly TRIG_US*CLK_HZ/1000000 cycles, then go to WAIT_ECHO; trig SHALL be 0 in all other states.
REQ-020 WAIT_ECHO: on a synchronized echo rise, go to MEASURE and clear the cm and sub-cm counters.
REQ-021 WAIT_ECHO: after ECHO_WAIT_US ticks with no rise, pulse timeout, hold distance unchanged, and go to HOLDOFF.
REQ-022 MEASURE: on every 58th us tick, increment the cm counter (truncating conversion).
REQ-023 MEASURE: on a synchronized echo fall, in the next cycle load distance with the cm count, pulse valid in that same cycle, and go to HOLDOFF.
REQ-024 MEASURE: when the cm count reaches MAX_CM, load distance=MAX_CM, pulse valid, and go to HOLDOFF without waiting for the fall.
REQ-025 HOLDOFF: wait until PERIOD_MS has elapsed since the trig rise; then go to TRIG if en=1, else go to IDLE.
REQ-026 HOLDOFF exit SHALL also require the synchronized echo to be low, so a stuck-high echo never retriggers.
REQ-027 Deasserting en mid-cycle SHALL NOT abort the measurement; the block SHALL stop only at the HOLDOFF exit.
REQ-028 valid and timeout SHALL never be asserted in the same cycle.
REQ-029 distance SHALL change only in the cycle valid=1.

Reset
REQ-030 rst=1 at any clock edge, in any state, SHALL force IDLE and clear every counter and the synchronizer flops.
REQ-031 During reset SHALL drive trig=0, distance=0, valid=0, timeout=0, busy=0.
REQ-032 A measurement interrupted by reset SHALL be discarded, with no valid pulse.

Structure
REQ-033 State encodings, the 58 us/cm constant, and derived cycle counts SHALL live in a shared header hc_sr04_defs.
REQ-034 The microsecond prescaler SHALL be one sub-module, us_tick (clk, rst, tick).

Verification
REQ-035 With CLK_HZ=12e6 and en=1 after reset: trig SHALL go high at clock 1 after en=1 is seen and stay high for exactly 120 cycles.
REQ-036 An echo of 580 us after trig SHALL produce distance=10 with one valid pulse; an echo of 637 us SHALL also produce 10; an echo of 57 us SHALL produce 0.
REQ-037 No echo SHALL produce a timeout pulse 30000 us after trig falls, with distance keeping its prior value of 10.
REQ-038 An echo held high for 30 ms SHALL produce distance=400 with valid, then no retrigger until echo is low.
REQ-039 Asserting rst 100 us into MEASURE SHALL give no valid pulse, distance=0, and a fresh trig after release.
REQ-040 Successive trig rising edges SHALL be 720000 cycles apart; deasserting en mid-MEASURE SHALL complete that measurement and then leave the block in IDLE.
